// File: rtl/grid_pkg.sv
// Shared grid geometry and seeder FSM encoding.
package grid_pkg;
    localparam int GRID_W = 64;
    localparam int GRID_H = 48;
    localparam int WORD_W = 8;
    localparam int WORDS  = GRID_W * GRID_H / WORD_W;
    localparam int ADDR_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_WRITE,
        ST_DONE
    } state_e;
endpackage

// File: rtl/grid_seeder_if.sv
// Grid-RAM write port: request, address and packed word, with ready back-pressure.
interface grid_seeder_if #(
    parameter int ADDR_W = 9,
    parameter int WORD_W = 8
);
    logic              o_wr_en;
    logic [ADDR_W-1:0] o_wr_addr;
    logic [WORD_W-1:0] o_wr_data;
    logic              i_wr_ready;

    modport master (output o_wr_en, output o_wr_addr, output o_wr_data, input i_wr_ready);
    modport slave  (input o_wr_en, input o_wr_addr, input o_wr_data, output i_wr_ready);
endinterface

// File: rtl/grid_seeder_bit_packer.sv
// Serial-in shift register: first bit shifted in ends at bit 0 after WORD_W shifts.
module bit_packer #(
    parameter int WORD_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clr,
    input  logic              i_shift,
    input  logic              i_bit,
    output logic [WORD_W-1:0] o_word,
    output logic              o_full
);
    localparam int CNT_W = $clog2(WORD_W + 1);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] word_q, word_d;

    always_comb begin
        cnt_d  = cnt_q;
        word_d = word_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_shift) begin
            word_d = {i_bit, word_q[WORD_W-1:1]};
            cnt_d  = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q  <= '0;
            word_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
        end
    end

    // Asserted on the shift that completes the word, so the FSM leaves FILL without a bubble.
    assign o_full = i_shift && !i_clr && (cnt_q == CNT_W'(WORD_W - 1));
    assign o_word = word_q;
endmodule

// File: rtl/grid_seeder.sv
// Fills the grid RAM with random cells, one packed word at a time.
module grid_seeder #(
    parameter int GRID_W = grid_pkg::GRID_W,
    parameter int GRID_H = grid_pkg::GRID_H,
    parameter int WORD_W = grid_pkg::WORD_W,
    parameter int ADDR_W = grid_pkg::ADDR_W
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_rnd,
    input  logic          i_start,
    input  logic          i_abort,
    grid_seeder_if.master wr_if,
    output logic          o_busy,
    output logic          o_done
);
    import grid_pkg::*;

    localparam int LAST = GRID_W * GRID_H / WORD_W - 1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              pk_clr, pk_shift, pk_full;
    logic [WORD_W-1:0] pk_word;

    bit_packer #(.WORD_W(WORD_W)) u_packer (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clr   (pk_clr),
        .i_shift (pk_shift),
        .i_bit   (i_rnd),
        .o_word  (pk_word),
        .o_full  (pk_full)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        pk_clr   = 1'b0;
        pk_shift = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (i_start && !i_abort) begin
                    state_d = ST_FILL;
                    addr_d  = '0;
                    pk_clr  = 1'b1;
                end
            end
            ST_FILL: begin
                if (i_abort) begin
                    state_d = ST_IDLE;
                end else begin
                    pk_shift = 1'b1;
                    if (pk_full) state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                // An accept coinciding with abort is already written; abort just stops here.
                if (i_abort) begin
                    state_d = ST_IDLE;
                end else if (wr_if.i_wr_ready) begin
                    if (addr_q == ADDR_W'(LAST)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_FILL;
                        addr_d  = addr_q + 1'b1;
                        pk_clr  = 1'b1;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    assign wr_if.o_wr_en   = (state_q == ST_WRITE);
    assign wr_if.o_wr_addr = addr_q;
    assign wr_if.o_wr_data = pk_word;
    assign o_busy          = (state_q != ST_IDLE);
    assign o_done          = (state_q == ST_DONE);
endmodule
